// File: rtl/render_pkg.sv
// render_pkg: shared perspective-divide state encoding, flag bit indices and saturation bounds
package render_pkg;

    typedef enum logic [1:0] {IDLE, DIV, FIX, OUT} pd_state_t;

    localparam int FLG_DIV0   = 0;
    localparam int FLG_BEHIND = 1;
    localparam int FLG_SAT    = 2;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/seq_udiv_step.sv
// seq_udiv_step: unsigned restoring divider datapath, one quotient bit per enabled cycle
//   clk, rst (sync, active-low) | load: capture dividend, clear remainder
//   en: one shift-subtract step | dividend [N], divisor [D] | quot [N]: quotient after N steps
module seq_udiv_step #(
    parameter int N = 24,
    parameter int D = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic [N-1:0] quot
);

    logic [D-1:0] rem;
    logic [D:0]   sh;
    logic         ge;

    // quot doubles as the dividend shift register: dividend bits leave at the top,
    // quotient bits enter at the bottom
    assign sh = {rem, quot[N-1]};
    assign ge = sh >= {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem  <= '0;
            quot <= '0;
        end else if (load) begin
            rem  <= '0;
            quot <= dividend;
        end else if (en) begin
            rem  <= D'(ge ? sh - {1'b0, divisor} : sh);
            quot <= {quot[N-2:0], ge};
        end
    end

endmodule

// File: rtl/persp_divide_unit.sv
// persp_divide_unit: perspective divide of a clip-space vertex into signed fixed-point x/w, y/w, z/w
//   CLK, rst (sync, active-low)
//   in_valid/in_ready, in_x/in_y/in_z/in_w [W] signed, in_tag [TAG_W]
//   out_valid/out_ready, out_x/out_y/out_z [W] signed with FRAC fraction bits, out_tag, out_flags [3]
//   out_flags: bit0 w==0, bit1 w<0, bit2 a component was clamped | busy: not IDLE
module persp_divide_unit
    import render_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int TAG_W = 2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_x,
    input  logic signed [W-1:0] in_y,
    input  logic signed [W-1:0] in_z,
    input  logic signed [W-1:0] in_w,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_x,
    output logic signed [W-1:0] out_y,
    output logic signed [W-1:0] out_z,
    output logic [TAG_W-1:0]    out_tag,
    output logic [2:0]          out_flags,
    output logic                busy
);

    localparam int ITER = W + FRAC;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0]   LAST = CW'(ITER - 1);
    localparam logic [W-1:0]    MAXV = W'(sat_max(W));
    localparam logic [W-1:0]    MINV = W'(sat_min(W));
    localparam logic [ITER-1:0] MAXM = ITER'(sat_max(W));
    localparam logic [ITER-1:0] MINM = ITER'(-sat_min(W));

    pd_state_t         st, nxt;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      cx, cy, cz, wr;
    logic [W:0]        wmag;
    logic [TAG_W-1:0]  tag_r;
    logic [ITER-1:0]   qx, qy, qz;
    logic [W:0]        fx, fy, fz;
    logic              acc, wz;

    // |-(2^(W-1))| still fits W unsigned bits, so the two's-complement negate is exact
    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    // {sat, value}: sign rule plus clamp; w==0 forces the signed extreme of the component
    function automatic logic [W:0] fixc(input logic [W-1:0] c, input logic [ITER-1:0] q,
                                        input logic z, input logic wn);
        logic neg, ov;
        logic [W-1:0] lo;
        neg = c[W-1] ^ wn;
        ov  = !z && (neg ? q > MINM : q > MAXM);
        lo  = q[W-1:0];
        return {ov, z ? (c[W-1] ? MINV : |c ? MAXV : {W{1'b0}})
                      : ov ? (neg ? MINV : MAXV) : (neg ? -lo : lo)};
    endfunction

    assign acc       = in_valid && st == IDLE;
    assign in_ready  = st == IDLE;
    assign out_valid = st == OUT;
    assign busy      = st != IDLE;
    assign wz        = ~|wr;
    assign fx        = fixc(cx, qx, wz, wr[W-1]);
    assign fy        = fixc(cy, qy, wz, wr[W-1]);
    assign fz        = fixc(cz, qz, wz, wr[W-1]);

    seq_udiv_step #(.N(ITER), .D(W + 1)) u_div_x (
        .clk(CLK), .rst(rst), .load(acc), .en(st == DIV),
        .dividend({mag(in_x), {FRAC{1'b0}}}), .divisor(wmag), .quot(qx)
    );
    seq_udiv_step #(.N(ITER), .D(W + 1)) u_div_y (
        .clk(CLK), .rst(rst), .load(acc), .en(st == DIV),
        .dividend({mag(in_y), {FRAC{1'b0}}}), .divisor(wmag), .quot(qy)
    );
    seq_udiv_step #(.N(ITER), .D(W + 1)) u_div_z (
        .clk(CLK), .rst(rst), .load(acc), .en(st == DIV),
        .dividend({mag(in_z), {FRAC{1'b0}}}), .divisor(wmag), .quot(qz)
    );

    always_ff @(posedge CLK) begin
        if (!rst) st <= IDLE;
        else      st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    if (in_valid) nxt = DIV;
            DIV:     if (cnt == LAST) nxt = FIX;
            FIX:     nxt = OUT;
            OUT:     if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            cnt       <= '0;
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            wr        <= '0;
            wmag      <= '0;
            tag_r     <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else begin
            cnt <= st == DIV ? cnt + 1'b1 : '0;
            if (acc) begin
                cx    <= in_x;
                cy    <= in_y;
                cz    <= in_z;
                wr    <= in_w;
                wmag  <= {1'b0, mag(in_w)};
                tag_r <= in_tag;
            end
            if (st == FIX) begin
                out_x                <= fx[W-1:0];
                out_y                <= fy[W-1:0];
                out_z                <= fz[W-1:0];
                out_tag              <= tag_r;
                out_flags[FLG_DIV0]   <= wz;
                out_flags[FLG_BEHIND] <= wr[W-1];
                out_flags[FLG_SAT]    <= fx[W] | fy[W] | fz[W];
            end
        end
    end

endmodule

// File: tb/tb_persp_divide_unit.sv
// tb_persp_divide_unit: directed and randomized checks of persp_divide_unit against an arithmetic model
module tb_persp_divide_unit;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_x = '0, in_y = '0, in_z = '0, in_w = '0;
    logic [1:0]         in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_x, out_y, out_z;
    logic [1:0]         out_tag;
    logic [2:0]         out_flags;
    logic               busy;

    int checks = 0;
    int failures = 0;
    bit rnd = 1'b0;

    typedef struct {
        int x, y, z, tag, flags;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    persp_divide_unit #(.W(16), .FRAC(8), .TAG_W(2)) dut (
        .CLK(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_w(in_w), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_tag(out_tag), .out_flags(out_flags), .busy(busy)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // trunc((c*256)/w) with saturation to 16-bit signed; w==0 yields the signed extreme of c
    function automatic exp_t model(input int x, input int y, input int z, input int w, input int tag);
        exp_t e;
        int c[3];
        longint v[3];
        bit sat;
        sat = 1'b0;
        c = '{x, y, z};
        for (int i = 0; i < 3; i++) begin
            if (w == 0) v[i] = c[i] > 0 ? 32767 : c[i] < 0 ? -32768 : 0;
            else begin
                v[i] = (longint'(c[i]) * 256) / w;
                if (v[i] > 32767) begin v[i] = 32767; sat = 1'b1; end
                else if (v[i] < -32768) begin v[i] = -32768; sat = 1'b1; end
            end
        end
        e.x = int'(v[0]);
        e.y = int'(v[1]);
        e.z = int'(v[2]);
        e.tag = tag;
        e.flags = (sat ? 4 : 0) + (w < 0 ? 2 : 0) + (w == 0 ? 1 : 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) q.delete();
        else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out actual=out_valid required=no_pending at %0t", $time);
                end else begin
                    chk("sb_x", out_x, q[0].x);
                    chk("sb_y", out_y, q[0].y);
                    chk("sb_z", out_z, q[0].z);
                    chk("sb_tag", out_tag, q[0].tag);
                    chk("sb_flags", out_flags, q[0].flags);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_x, in_y, in_z, in_w, in_tag));
        end
    end

    task automatic send(input logic signed [15:0] x, y, z, w, input logic [1:0] t);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_x = x; in_y = y; in_z = z; in_w = w; in_tag = t;
        in_valid = 1'b1;
        while (!ok && n < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
        end
        in_valid = 1'b0;
    endtask

    // edges after the accept edge until out_valid is seen
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_one(input logic signed [15:0] x, y, z, w, input logic [1:0] t,
                           input int ex, ey, ez, ef);
        int n;
        send(x, y, z, w, t);
        wait_valid(n);
        chk("latency", n + 1, 26);
        chk("out_x", out_x, ex);
        chk("out_y", out_y, ey);
        chk("out_z", out_z, ez);
        chk("out_tag", out_tag, t);
        chk("out_flags", out_flags, ef);
        @(posedge clk); #1;
    endtask

    function automatic logic signed [15:0] rcomp();
        case ($urandom_range(0, 5))
            0:       return 16'sh8000;
            1:       return 16'sh7fff;
            2:       return 16'sh0000;
            3:       return 16'(int'($urandom_range(0, 16)) - 8);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        exp_t m;
        int n;
        m = model(100, -50, 25, 100, 0);
        chk("model_nominal_x", m.x, 256);
        chk("model_nominal_y", m.y, -128);
        m = model(4, 0, -3, -2, 0);
        chk("model_behind_z", m.z, 384);
        chk("model_behind_flags", m.flags, 2);
        m = model(-32768, 0, 0, -1, 0);
        chk("model_negmin_sat", m.x, 32767);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_flags", out_flags, 0);
        rst = 1'b1;
        out_ready = 1'b1;

        run_one(100, -50, 25, 100, 1, 256, -128, 64, 0);
        run_one(4, 0, -3, -2, 2, -512, 0, 384, 2);
        run_one(5, -5, 0, 0, 3, 32767, -32768, 0, 1);
        run_one(1000, 0, 0, 1, 0, 32767, 0, 0, 4);

        out_ready = 1'b0;
        send(7, -7, 300, 3, 1);
        wait_valid(n);
        chk("bp_latency", n + 1, 26);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_x", out_x, 597);
            chk("bp_y", out_y, -597);
            chk("bp_z", out_z, 25600);
            chk("bp_tag", out_tag, 1);
            chk("bp_flags", out_flags, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);

        send(100, 0, 0, 100, 2);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_x", out_x, 0);
        chk("midrst_flags", out_flags, 0);
        run_one(100, 0, 0, 100, 3, 256, 0, 0, 0);

        rnd = 1'b1;
        for (int i = 0; i < 200; i++) send(rcomp(), rcomp(), rcomp(), rcomp(), 2'($urandom));
        rnd = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
